// File: rtl/display_pkg.sv
// Shared raster constants and types for the scoreboard display path.
// Renderers import the coordinate widths and box geometry from here.
package display_pkg;

    localparam int PIX_X_W = 11;
    localparam int PIX_Y_W = 10;

    // 800x600 @ 72 Hz with a 50 MHz pixel clock
    localparam int DEF_H_ACTIVE     = 800;
    localparam int DEF_H_FP         = 56;
    localparam int DEF_H_SYNC       = 120;
    localparam int DEF_H_BP         = 64;
    localparam int DEF_V_ACTIVE     = 600;
    localparam int DEF_V_FP         = 37;
    localparam int DEF_V_SYNC       = 6;
    localparam int DEF_V_BP         = 23;
    localparam int DEF_BLINK_FRAMES = 36;

    localparam int BOX_X0 = 40;
    localparam int BOX_Y0 = 40;
    localparam int BOX_X1 = 759;
    localparam int BOX_Y1 = 559;

    typedef struct packed {
        logic [PIX_X_W-1:0] x;
        logic [PIX_Y_W-1:0] y;
        logic               video_on;
        logic               hsync;
        logic               vsync;
        logic               frame_start;
    } raster_t;

    function automatic int span_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/blink_divider.sv
// Divides the frame-start strobe down to a blink toggle; blink flips on
// every BLINK_FRAMES-th tick, the first flip on the BLINK_FRAMES-th tick.
module blink_divider #(
    parameter int BLINK_FRAMES = 36
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    output logic blink
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_FRAMES - 1);

    if (BLINK_FRAMES < 1) begin : g_param_check
        $error("blink_divider: BLINK_FRAMES must be at least 1");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (tick) begin
            if (cnt == LAST) begin
                cnt   <= '0;
                blink <= ~blink;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: coordinates, active-video, syncs, frame strobe and
// blink, all registered from the next counter values so they never skew.
module vga_timing_gen
    import display_pkg::*;
#(
    parameter int H_ACTIVE     = DEF_H_ACTIVE,
    parameter int H_FP         = DEF_H_FP,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int H_BP         = DEF_H_BP,
    parameter int V_ACTIVE     = DEF_V_ACTIVE,
    parameter int V_FP         = DEF_V_FP,
    parameter int V_SYNC       = DEF_V_SYNC,
    parameter int V_BP         = DEF_V_BP,
    parameter bit HS_POL       = 1'b1,
    parameter bit VS_POL       = 1'b1,
    parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_en,
    output logic [PIX_X_W-1:0] pixel_x,
    output logic [PIX_Y_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start,
    output logic               blink
);

    localparam int H_TOTAL  = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [PIX_X_W-1:0] H_LAST = PIX_X_W'(H_TOTAL - 1);
    localparam logic [PIX_Y_W-1:0] V_LAST = PIX_Y_W'(V_TOTAL - 1);

    if (H_TOTAL > 2048 || V_TOTAL > 1024 || BLINK_FRAMES < 1) begin : g_param_check
        $error("vga_timing_gen: totals exceed coordinate widths or BLINK_FRAMES < 1");
    end

    logic [PIX_X_W-1:0] h_cnt, h_nxt;
    logic [PIX_Y_W-1:0] v_cnt, v_nxt;
    logic               h_wrap;
    logic               fs_nxt;
    raster_t            nxt;

    // Counters reset to the last position so the first enabled edge lands on (0,0).
    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? '0 : h_cnt + PIX_X_W'(1);
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + PIX_Y_W'(1);
        end
        fs_nxt = pix_en && (h_nxt == '0) && (v_nxt == '0);

        nxt.x           = h_nxt;
        nxt.y           = v_nxt;
        nxt.video_on    = (int'(h_nxt) < H_ACTIVE) && (int'(v_nxt) < V_ACTIVE);
        nxt.hsync       = ((int'(h_nxt) >= HS_START) && (int'(h_nxt) < HS_END)) ? HS_POL : ~HS_POL;
        nxt.vsync       = ((int'(v_nxt) >= VS_START) && (int'(v_nxt) < VS_END)) ? VS_POL : ~VS_POL;
        nxt.frame_start = fs_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt       <= H_LAST;
            v_cnt       <= V_LAST;
            pixel_x     <= '0;
            pixel_y     <= '0;
            video_on    <= 1'b0;
            hsync       <= ~HS_POL;
            vsync       <= ~VS_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (pix_en) begin
                h_cnt       <= h_nxt;
                v_cnt       <= v_nxt;
                pixel_x     <= nxt.x;
                pixel_y     <= nxt.y;
                video_on    <= nxt.video_on;
                hsync       <= nxt.hsync;
                vsync       <= nxt.vsync;
                frame_start <= nxt.frame_start;
            end
        end
    end

    // Fed the pre-register strobe so blink flips on the same edge as frame_start.
    blink_divider #(
        .BLINK_FRAMES(BLINK_FRAMES)
    ) u_blink (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (fs_nxt),
        .blink(blink)
    );

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, tiny and short-line instances driven in
// lockstep, checked against a position-from-enable-count model.
module tb_vga_timing_gen;
    import display_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pix_en = 1'b0;

    logic [10:0] xa, xb, xc;
    logic [9:0]  ya, yb, yc;
    logic voa, hsa, vsa, fsa, bla;
    logic vob, hsb, vsb, fsb, blb;
    logic voc, hsc, vsc, fsc, blc;
    logic [25:0] oa, ob, oc;

    assign oa = {xa, ya, voa, hsa, vsa, fsa, bla};
    assign ob = {xb, yb, vob, hsb, vsb, fsb, blb};
    assign oc = {xc, yc, voc, hsc, vsc, fsc, blc};

    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .pixel_x(xa), .pixel_y(ya), .video_on(voa), .hsync(hsa), .vsync(vsa),
        .frame_start(fsa), .blink(bla)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .BLINK_FRAMES(2)
    ) u_b (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .pixel_x(xb), .pixel_y(yb), .video_on(vob), .hsync(hsb), .vsync(vsb),
        .frame_start(fsb), .blink(blb)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2)
    ) u_c (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en),
        .pixel_x(xc), .pixel_y(yc), .video_on(voc), .hsync(hsc), .vsync(vsc),
        .frame_start(fsc), .blink(blc)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int n = 0;        // enabled edges since reset release
    bit fs_ok = 1'b0; // last edge was enabled and out of reset

    typedef struct {
        int n;
        int x;
        int y;
        bit vo, hs, vs, fs, bl;
    } vec_t;

    vec_t tbl[10];

    // Position k = n-1 in raster order; frame starts seen so far = k / frame + 1.
    function automatic logic [25:0] model(int cnt, bit en_edge, int ha, int hf, int hs, int hb,
                                          int va, int vf, int vs, int vb, int bf);
        int ht, vt, k, x, y, frames;
        logic vo, h, v, fs, bl;
        if (cnt == 0) return 26'd0;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        k = cnt - 1;
        x = k % ht;
        y = (k / ht) % vt;
        frames = k / (ht * vt) + 1;
        vo = (x < ha) && (y < va);
        h  = (x >= ha + hf) && (x < ha + hf + hs);
        v  = (y >= va + vf) && (y < va + vf + vs);
        fs = en_edge && (x == 0) && (y == 0);
        bl = ((frames / bf) % 2) == 1;
        return {11'(x), 10'(y), vo, h, v, fs, bl};
    endfunction

    function automatic logic [25:0] pack(vec_t t);
        return {11'(t.x), 10'(t.y), t.vo, t.hs, t.vs, t.fs, t.bl};
    endfunction

    task automatic chk(string name, logic [25:0] got, logic [25:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s n=%0d got=%h expected=%h", name, n, got, exp);
        end
    endtask

    task automatic check_all();
        chk("dut_default", oa, model(n, fs_ok, 800, 56, 120, 64, 600, 37, 6, 23, 36));
        chk("dut_small",   ob, model(n, fs_ok, 8, 2, 2, 2, 4, 1, 1, 1, 2));
        chk("dut_shortln", oc, model(n, fs_ok, 8, 2, 2, 2, 600, 37, 6, 23, 36));
    endtask

    task automatic step(bit en);
        pix_en = en;
        @(posedge clk);
        if (rst_n) begin
            fs_ok = en;
            if (en) n++;
        end else begin
            fs_ok = 1'b0;
        end
        #1;
        check_all();
        // tiny instance: 98 clks per frame, blink rises at fs #2, falls at fs #4
        if (en && n == 98)  chk("small_pre_blink",  {24'd0, fsb, blb}, 26'b00);
        if (en && n == 99)  chk("small_blink_rise", {24'd0, fsb, blb}, 26'b11);
        if (en && n == 295) chk("small_blink_fall", {24'd0, fsb, blb}, 26'b10);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog n=%0d got=timeout expected=finish", n);
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1,    0,    0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{2,    1,    0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{800,  799,  0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{801,  800,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{856,  855,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{857,  856,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{976,  975,  0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{977,  976,  0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1040, 1039, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[9] = '{1041, 0,    1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        // reset held with pix_en high: outputs must stay at reset values
        repeat (3) step(1'b1);
        chk("reset_default", oa, 26'd0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            while (n < tbl[i].n) step(1'b1);
            chk($sformatf("line_vec%0d", i), oa, pack(tbl[i]));
        end

        // half-rate enable: one line of 1040 pixels takes 2080 clks
        for (int i = 0; i < 2080; i++) step((i % 2) == 0);
        chk("half_rate_line", {5'd0, xa, ya}, {5'd0, 11'd0, 10'd2});

        // random enable long enough for the short-line instance to wrap a frame
        for (int i = 0; i < 13000; i++) step($urandom_range(0, 3) != 0);
        chk("shortln_frame_wrapped", {25'd0, (n > 9325)}, 26'd1);

        // asynchronous reset mid-line, checked before the next edge
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n = 0;
        fs_ok = 1'b0;
        chk("async_rst_default", oa, 26'd0);
        chk("async_rst_small",   ob, 26'd0);
        chk("async_rst_shortln", oc, 26'd0);
        step(1'b1);
        step(1'b1);
        rst_n = 1'b1;
        step(1'b1);
        chk("restart_default", {3'd0, xa, ya, fsa, bla}, {3'd0, 11'd0, 10'd0, 1'b1, 1'b0});
        chk("restart_small",   {24'd0, fsb, blb}, 26'b10);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
